// File: rtl/wb_spram_pkg.sv
// Shared definitions for the Wishbone single-port RAM controller.
//   state_t     : controller states (INIT, IDLE, ACK, ERR)
//   WB_LANES    : number of byte lanes on the 32-bit data path
//   in_window() : true when a byte address falls inside the RAM window
package wb_spram_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACK,
        ST_ERR
    } state_t;

    localparam int unsigned WB_DATA_BITS = 32;
    localparam int unsigned WB_LANES     = WB_DATA_BITS / 8;

    // The window is aligned to its own size, so only the bits above the
    // word index have to match the base address.
    function automatic logic in_window(input logic [31:0]   adr,
                                       input logic [31:0]   base,
                                       input int unsigned   addr_bits);
        logic [31:0] diff;
        diff = adr ^ base;
        return ((diff >> (addr_bits + 2)) == '0);
    endfunction

endpackage

// File: rtl/wb_spram_ctrl_if.sv
// Wishbone B4 classic bus bundle for wb_spram_ctrl.
//   master : drives cyc/stb/we/adr/sel/dat_i, receives dat_o/ack/err
//   slave  : the mirror image
interface wb_spram_ctrl_if;
    import wb_spram_pkg::*;

    logic                wb_cyc_i;
    logic                wb_stb_i;
    logic                wb_we_i;
    logic [31:0]         wb_adr_i;
    logic [WB_LANES-1:0] wb_sel_i;
    logic [31:0]         wb_dat_i;
    logic [31:0]         wb_dat_o;
    logic                wb_ack_o;
    logic                wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/wb_spram_ctrl.sv
// Wishbone B4 classic slave owning a single-port byte-enable SRAM macro.
// Zero-fills the array after reset, then serves reads/writes with one wait
// state; out-of-window accesses terminate with wb_err_o.
//   clock, reset_n : clock and asynchronous active-low reset
//   wb             : Wishbone slave port (cyc/stb/we/adr/sel/dat in, dat/ack/err out)
//   ram_adr        : RAM word address
//   ram_dat_o      : RAM write data
//   ram_we         : RAM write enable
//   ram_sel        : RAM byte-lane enables
//   ram_dat_i      : RAM read data, registered one cycle after ram_adr
//   init_done      : high once the zero-fill has completed
module wb_spram_ctrl
    import wb_spram_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 9,
    parameter int unsigned DATA_BITS = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter bit          INIT_EN   = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    wb_spram_ctrl_if.slave         wb,
    output logic [ADDR_BITS-1:0]   ram_adr,
    output logic [DATA_BITS-1:0]   ram_dat_o,
    output logic                   ram_we,
    output logic [WB_LANES-1:0]    ram_sel,
    input  logic [DATA_BITS-1:0]   ram_dat_i,
    output logic                   init_done
);

    localparam state_t                RESET_STATE = INIT_EN ? ST_INIT : ST_IDLE;
    localparam logic [ADDR_BITS-1:0]  FILL_LAST   = '1;

    state_t               state_q;
    state_t               state_d;
    logic [ADDR_BITS-1:0] fill_q;
    logic                 we_q;
    logic                 init_done_q;

    logic                 req;
    logic                 hit;

    assign req       = wb.wb_cyc_i & wb.wb_stb_i;
    assign hit       = in_window(wb.wb_adr_i, BASE_ADDR, ADDR_BITS);
    assign init_done = init_done_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET_STATE;
            fill_q      <= '0;
            we_q        <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Counter parks on the last word so the fill can never wrap.
            if (state_q == ST_INIT && fill_q != FILL_LAST)
                fill_q <= fill_q + 1'b1;
            if (state_q == ST_IDLE && req && hit)
                we_q <= wb.wb_we_i;
            if (state_d != ST_INIT)
                init_done_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ram_adr     = '0;
        ram_dat_o   = '0;
        ram_we      = 1'b0;
        ram_sel     = '0;
        wb.wb_ack_o = 1'b0;
        wb.wb_err_o = 1'b0;
        wb.wb_dat_o = '0;

        unique case (state_q)
            ST_INIT: begin
                ram_adr = fill_q;
                ram_we  = 1'b1;
                ram_sel = '1;
                if (fill_q == FILL_LAST)
                    state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (req) begin
                    if (hit) begin
                        ram_adr   = wb.wb_adr_i[ADDR_BITS+1:2];
                        ram_dat_o = wb.wb_dat_i;
                        ram_sel   = wb.wb_sel_i;
                        ram_we    = wb.wb_we_i;
                        state_d   = ST_ACK;
                    end else begin
                        state_d   = ST_ERR;
                    end
                end
            end
            ST_ACK: begin
                wb.wb_ack_o = 1'b1;
                if (!we_q)
                    wb.wb_dat_o = ram_dat_i;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                wb.wb_err_o = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = RESET_STATE;
        endcase

        // The RAM strobes are decoded from state combinationally; hold them
        // quiet while reset is asserted so no write leaks out during reset.
        if (!reset_n) begin
            ram_adr   = '0;
            ram_dat_o = '0;
            ram_we    = 1'b0;
            ram_sel   = '0;
        end
    end

endmodule

// File: tb/tb_wb_spram_ctrl.sv
// Self-checking bench for wb_spram_ctrl with a behavioural SRAM macro and a
// word-array reference model of the RAM contents.
module tb_wb_spram_ctrl;

    localparam int unsigned AB     = 4;
    localparam int unsigned WORDS  = 1 << AB;
    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] WIN_SZ = 32'(4 * WORDS);

    logic          clock;
    logic          reset_n;
    logic [AB-1:0] ram_adr;
    logic [31:0]   ram_dat_o;
    logic          ram_we;
    logic [3:0]    ram_sel;
    logic [31:0]   ram_dat_i;
    logic          init_done;

    wb_spram_ctrl_if bus ();

    wb_spram_ctrl #(
        .ADDR_BITS (AB),
        .DATA_BITS (32),
        .BASE_ADDR (BASE),
        .INIT_EN   (1'b1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wb        (bus.slave),
        .ram_adr   (ram_adr),
        .ram_dat_o (ram_dat_o),
        .ram_we    (ram_we),
        .ram_sel   (ram_sel),
        .ram_dat_i (ram_dat_i),
        .init_done (init_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM macro stand-in: byte-lane writes, registered read.
    logic [31:0] sram [WORDS];
    initial for (int i = 0; i < WORDS; i++) sram[i] = 32'hA5A5_0000 + 32'(i);
    always @(posedge clock) begin
        if (ram_we)
            for (int l = 0; l < 4; l++)
                if (ram_sel[l]) sram[ram_adr][8*l +: 8] <= ram_dat_o[8*l +: 8];
        ram_dat_i <= sram[ram_adr];
    end

    // Reference model
    logic [31:0] ref_mem [WORDS];
    int tests = 0;
    int fails = 0;

    function automatic bit ref_in_win(input logic [31:0] adr);
        return (adr >= BASE) && ((adr - BASE) < WIN_SZ);
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] sel);
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_dat_i = '0;
    endtask

    // Checks ram strobes/counter once per cycle for the whole fill, sampled
    // mid-cycle; returns one cycle after the final fill edge.
    task automatic fill_check(input string tag);
        for (int k = 0; k < WORDS; k++) begin
            check({tag, "_we"},   32'(ram_we),    32'd1);
            check({tag, "_sel"},  32'(ram_sel),   32'hF);
            check({tag, "_adr"},  32'(ram_adr),   32'(k));
            check({tag, "_dat"},  ram_dat_o,      32'd0);
            check({tag, "_done"}, 32'(init_done), 32'd0);
            check({tag, "_term"}, 32'({bus.wb_ack_o, bus.wb_err_o}), 32'd0);
            @(negedge clock); #1;
        end
        check({tag, "_done_rise"}, 32'(init_done), 32'd1);
    endtask

    // One Wishbone access checked against the reference model.
    task automatic do_op(input string tag, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat,
                         output logic [31:0] rdata);
        bit          inwin;
        int          w;
        logic [31:0] exp_rd;
        logic        we_seen, ack, err;
        int          lat;

        inwin  = ref_in_win(adr);
        w      = int'((adr - BASE) >> 2);
        exp_rd = (inwin && !we) ? ref_mem[w] : 32'd0;

        @(posedge clock); #1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_sel_i = sel;
        bus.wb_dat_i = dat;
        #1;
        we_seen = ram_we;
        ack = 1'b0; err = 1'b0; rdata = 'x; lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            lat = c;
            if (bus.wb_ack_o || bus.wb_err_o) begin
                ack   = bus.wb_ack_o;
                err   = bus.wb_err_o;
                rdata = bus.wb_dat_o;
                break;
            end
        end
        bus_idle();
        check({tag, "_lat"},   32'(lat),         32'd1);
        check({tag, "_ack"},   32'(ack),         32'(inwin));
        check({tag, "_err"},   32'(err),         32'(!inwin));
        check({tag, "_rdat"},  rdata,            exp_rd);
        check({tag, "_ramwe"}, 32'(we_seen),     32'(inwin && we));
        @(posedge clock); #1;
        check({tag, "_1cyc"},  32'({bus.wb_ack_o, bus.wb_err_o}), 32'd0);
        if (inwin && we) ref_mem[w] = ref_merge(ref_mem[w], dat, sel);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] adr;
        int          cyc;

        bus_idle();
        reset_n = 1'b0;
        ref_clear();
        repeat (3) @(negedge clock);
        #1;
        check("rst_we",   32'(ram_we),    32'd0);
        check("rst_sel",  32'(ram_sel),   32'd0);
        check("rst_adr",  32'(ram_adr),   32'd0);
        check("rst_dat",  ram_dat_o,      32'd0);
        check("rst_done", 32'(init_done), 32'd0);
        check("rst_term", 32'({bus.wb_ack_o, bus.wb_err_o}), 32'd0);
        check("rst_rdat", bus.wb_dat_o,   32'd0);

        @(negedge clock);
        reset_n = 1'b1;
        #1;
        fill_check("fill");
        check("idle_we", 32'(ram_we), 32'd0);

        do_op("rd7_zero", 1'b0, BASE + 32'h1C, 4'hF, 32'h0, rd);
        do_op("wr_dead",  1'b1, BASE + 32'h08, 4'hF, 32'hDEAD_BEEF, rd);
        do_op("rd_dead",  1'b0, BASE + 32'h08, 4'hF, 32'h0, rd);
        do_op("wr_lane",  1'b1, BASE + 32'h08, 4'b0101, 32'h1122_3344, rd);
        do_op("rd_lane",  1'b0, BASE + 32'h0B, 4'hF, 32'h0, rd);
        check("lane0", 32'(rd[7:0]),   32'h44);
        check("lane1", 32'(rd[15:8]),  32'hBE);
        check("lane2", 32'(rd[23:16]), 32'h22);
        check("lane3", 32'(rd[31:24]), 32'hDE);

        do_op("err_top",  1'b1, BASE + WIN_SZ, 4'hF, 32'hFFFF_FFFF, rd);
        do_op("rd_after", 1'b0, BASE + 32'h08, 4'hF, 32'h0, rd);
        do_op("err_low",  1'b0, 32'h2000_0008, 4'hF, 32'h0, rd);
        do_op("wr_sel0",  1'b1, BASE + 32'h08, 4'h0, 32'h0BAD_F00D, rd);
        do_op("rd_sel0",  1'b0, BASE + 32'h08, 4'hF, 32'h0, rd);
        do_op("wr_last",  1'b1, BASE + WIN_SZ - 4, 4'hF, 32'h5555_AAAA, rd);
        do_op("rd_last",  1'b0, BASE + WIN_SZ - 1, 4'hF, 32'h0, rd);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(7) == 0)
                adr = ($urandom_range(1) == 0) ? BASE + WIN_SZ + 32'($urandom_range(255))
                                               : BASE - 32'd4 - 32'($urandom_range(255));
            else
                adr = BASE + 32'($urandom_range(WORDS - 1) * 4) + 32'($urandom_range(3));
            do_op("rand", 1'($urandom_range(1)), adr, 4'($urandom_range(15)), $urandom, rd);
        end

        // Strobe held from reset release: stalled through the fill.
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n      = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = BASE + 32'h14;
        bus.wb_sel_i = 4'hF;
        bus.wb_dat_i = 32'hCAFE_F00D;
        ref_clear();
        #1;
        fill_check("stall");
        check("stall_idle_we",  32'(ram_we),  32'd1);
        check("stall_idle_adr", 32'(ram_adr), 32'd5);
        cyc = 0;
        while (!bus.wb_ack_o && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("stall_ack_lat", 32'(cyc), 32'd1);
        bus_idle();
        ref_mem[5] = 32'hCAFE_F00D;
        do_op("rd_stall", 1'b0, BASE + 32'h14, 4'hF, 32'h0, rd);
        do_op("wr_w12",   1'b1, BASE + 32'h30, 4'hF, 32'h1234_5678, rd);

        // Reset mid-fill: restart from word 0 and run the full fill.
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        #1;
        check("mid_adr5", 32'(ram_adr), 32'd5);
        reset_n = 1'b0;
        #1;
        check("mid_rst_we",   32'(ram_we),    32'd0);
        check("mid_rst_adr",  32'(ram_adr),   32'd0);
        check("mid_rst_done", 32'(init_done), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        ref_clear();
        #1;
        fill_check("refill");
        do_op("rd_w12", 1'b0, BASE + 32'h30, 4'hF, 32'h0, rd);
        do_op("rd_w5",  1'b0, BASE + 32'h14, 4'hF, 32'h0, rd);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
